// File: rtl/seven_seg_shift_out.sv
// Parametrised serial display driver: CHAINS lockstep shift chains sharing one
// SCLK and one LATCH, programmable SCLK rate, one-deep pending frame buffer.

// One chain's shift register; presents the current bit on o_bit.
module seven_seg_chain #(
  parameter int WIDTH     = 84,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_bit
);
  logic [WIDTH-1:0] r_sh;

  // Load a new frame, or advance one bit toward the output end.
  always_ff @(posedge clk_i) begin
    if (rst_i)        r_sh <= '0;
    else if (i_load)  r_sh <= i_data;
    else if (i_shift) r_sh <= (LSB_FIRST != 0) ? {1'b0, r_sh[WIDTH-1:1]}
                                               : {r_sh[WIDTH-2:0], 1'b0};
  end

  assign o_bit = (LSB_FIRST != 0) ? r_sh[0] : r_sh[WIDTH-1];
endmodule

module seven_seg_shift_out #(
  parameter int WIDTH     = 84,
  parameter int CHAINS    = 1,
  parameter int CLK_DIV   = 1,
  parameter int LSB_FIRST = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [CHAINS*WIDTH-1:0] data_i,
  output logic                    sclk_o,
  output logic [CHAINS-1:0]       data_o,
  output logic                    latch_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    overrun_o
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, LATCH} state_t;

  state_t                  r_state, w_state_nxt;
  logic [PW-1:0]           r_phase;
  logic [BW-1:0]           r_bit;
  logic                    r_pend;
  logic [CHAINS*WIDTH-1:0] r_pend_data;
  logic                    r_sclk, r_latch, r_busy, r_done, r_ovr;

  logic                    w_ph_end, w_load, w_shift;
  logic [CHAINS*WIDTH-1:0] w_load_data;

  assign w_ph_end    = (r_phase == PH_LAST);
  // A fresh start always beats a waiting frame.
  assign w_load      = (r_state == IDLE) && (start_i || r_pend);
  assign w_load_data = start_i ? data_i : r_pend_data;
  // Shift on the HIGH->LOW boundary only; the last bit stays up through LATCH.
  assign w_shift     = (r_state == HIGH) && w_ph_end && (r_bit != BIT_LAST);

  // State register plus phase and bit counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= ((r_state == IDLE) || w_ph_end) ? '0 : r_phase + 1'b1;
      if (r_state == IDLE)                   r_bit <= '0;
      else if ((r_state == HIGH) && w_ph_end) r_bit <= r_bit + 1'b1;
    end
  end

  // Next-state: every non-idle phase lasts exactly CLK_DIV cycles.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_i || r_pend) w_state_nxt = LOW;
      LOW:     if (w_ph_end) w_state_nxt = HIGH;
      HIGH:    if (w_ph_end) w_state_nxt = (r_bit == BIT_LAST) ? LATCH : LOW;
      LATCH:   if (w_ph_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pending buffer: filled by starts while busy, drained (or overridden) in IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend      <= 1'b0;
      r_pend_data <= '0;
      r_ovr       <= 1'b0;
    end else begin
      r_ovr <= start_i && r_pend;
      if (r_state == IDLE) begin
        r_pend <= 1'b0;
      end else if (start_i) begin
        r_pend      <= 1'b1;
        r_pend_data <= data_i;
      end
    end
  end

  // Outputs registered from the next state so they line up with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sclk  <= 1'b0;
      r_latch <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_sclk  <= (w_state_nxt == HIGH);
      r_latch <= (w_state_nxt == LATCH);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (r_state == LATCH) && w_ph_end;
    end
  end

  assign sclk_o    = r_sclk;
  assign latch_o   = r_latch;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign overrun_o = r_ovr;

  for (genvar c = 0; c < CHAINS; c++) begin : g_chain
    seven_seg_chain #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_chain (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (w_load_data[c*WIDTH +: WIDTH]),
      .o_bit   (data_o[c])
    );
  end
endmodule

// File: tb/tb_seven_seg_shift_out.sv
// Bench for seven_seg_shift_out: three configurations, each compared every
// cycle against a frame-level timing model derived from the frame length.
module tb_seven_seg_shift_out;
  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic [2:0]  rst, st;
  logic [15:0] d0, d1;
  logic [83:0] d2;
  logic [2:0]  sclk, latch, busy, done, ovr;
  logic [1:0]  q0, q1;
  logic [0:0]  q2;

  seven_seg_shift_out #(.WIDTH(8), .CHAINS(2), .CLK_DIV(2), .LSB_FIRST(0)) u_dut0 (
    .clk_i(gclk), .rst_i(rst[0]), .start_i(st[0]), .data_i(d0), .sclk_o(sclk[0]),
    .data_o(q0), .latch_o(latch[0]), .busy_o(busy[0]), .done_o(done[0]), .overrun_o(ovr[0]));
  seven_seg_shift_out #(.WIDTH(8), .CHAINS(2), .CLK_DIV(2), .LSB_FIRST(1)) u_dut1 (
    .clk_i(gclk), .rst_i(rst[1]), .start_i(st[1]), .data_i(d1), .sclk_o(sclk[1]),
    .data_o(q1), .latch_o(latch[1]), .busy_o(busy[1]), .done_o(done[1]), .overrun_o(ovr[1]));
  seven_seg_shift_out u_dut2 (
    .clk_i(gclk), .rst_i(rst[2]), .start_i(st[2]), .data_i(d2), .sclk_o(sclk[2]),
    .data_o(q2), .latch_o(latch[2]), .busy_o(busy[2]), .done_o(done[2]), .overrun_o(ovr[2]));

  int W[3]    = '{8, 8, 84};
  int C[3]    = '{2, 2, 1};
  int D[3]    = '{2, 2, 1};
  int LSBF[3] = '{0, 1, 0};

  int n_chk = 0, n_fail = 0;
  // model state per instance
  int           t[3];
  int           m_start[3];
  bit           m_act[3], m_pend[3], m_ovr[3];
  logic [167:0] m_cur[3], m_pdata[3];
  logic [1:0]   m_hold[3];
  // observation
  logic [83:0]  cap[3][2];
  int           rises[3], ovr_cnt[3];
  bit           psclk[3];

  task automatic chk(input string tag, input logic [167:0] obs, input logic [167:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [167:0] rnd168();
    logic [167:0] v = '0;
    for (int i = 0; i < 6; i++) v = {v[135:0], $urandom()};
    return v;
  endfunction

  task automatic clear(input int id);
    cap[id][0] = '0; cap[id][1] = '0; rises[id] = 0; ovr_cnt[id] = 0;
  endtask

  // One cycle: check outputs against the model, then apply this cycle's inputs.
  task automatic tick(input int id, input bit s, input logic [167:0] d, input bit r);
    int L, k, p, j;
    bit e_busy, e_done, e_sclk, e_latch, idle_now;
    logic [1:0] o_data;
    @(negedge gclk);
    L = (2 * W[id] + 1) * D[id];
    e_busy  = m_act[id] && (t[id] >= m_start[id] + 1) && (t[id] <= m_start[id] + L);
    e_done  = m_act[id] && (t[id] == m_start[id] + L + 1);
    e_sclk  = 1'b0;
    e_latch = 1'b0;
    if (e_busy) begin
      k = t[id] - m_start[id] - 1;
      p = k / D[id];
      if (p < 2 * W[id]) begin
        e_sclk = (p % 2) == 1;
        j = p / 2;
      end else begin
        e_latch = 1'b1;
        j = W[id] - 1;
      end
      for (int c = 0; c < C[id]; c++)
        m_hold[id][c] = m_cur[id][c * W[id] + ((LSBF[id] != 0) ? j : W[id] - 1 - j)];
    end
    o_data = (id == 0) ? q0 : (id == 1) ? q1 : {1'b0, q2};
    chk($sformatf("i%0d_busy@%0d", id, t[id]), busy[id], e_busy);
    chk($sformatf("i%0d_done@%0d", id, t[id]), done[id], e_done);
    chk($sformatf("i%0d_sclk@%0d", id, t[id]), sclk[id], e_sclk);
    chk($sformatf("i%0d_latch@%0d", id, t[id]), latch[id], e_latch);
    chk($sformatf("i%0d_ovr@%0d", id, t[id]), ovr[id], m_ovr[id]);
    chk($sformatf("i%0d_data@%0d", id, t[id]), o_data, m_hold[id]);
    if (ovr[id]) ovr_cnt[id]++;
    if (sclk[id] && !psclk[id]) begin
      rises[id]++;
      for (int c = 0; c < C[id]; c++) cap[id][c] = {cap[id][c][82:0], o_data[c]};
    end
    psclk[id] = sclk[id];
    rst[id] = r;
    st[id]  = s;
    case (id)
      0: d0 = d[15:0];
      1: d1 = d[15:0];
      default: d2 = d[83:0];
    endcase
    if (r) begin
      m_act[id] = 1'b0; m_pend[id] = 1'b0; m_ovr[id] = 1'b0; m_hold[id] = '0;
    end else begin
      idle_now = !(m_act[id] && (t[id] <= m_start[id] + L));
      m_ovr[id] = s && m_pend[id];
      if (idle_now) begin
        if (s || m_pend[id]) begin
          m_cur[id]   = s ? d : m_pdata[id];
          m_start[id] = t[id];
          m_act[id]   = 1'b1;
          m_pend[id]  = 1'b0;
        end
      end else if (s) begin
        m_pend[id]  = 1'b1;
        m_pdata[id] = d;
      end
    end
    t[id]++;
  endtask

  task automatic idle(input int id, input int n);
    for (int i = 0; i < n; i++) tick(id, 1'b0, '0, 1'b0);
  endtask

  task automatic rnd_run(input int id, input int n);
    for (int i = 0; i < n; i++)
      tick(id, $urandom_range(0, 11) == 0, rnd168(), $urandom_range(0, 249) == 0);
  endtask

  initial begin
    logic [15:0]  a, b, c16, e, f, g;
    logic [167:0] big;
    rst = '1; st = '0; d0 = '0; d1 = '0; d2 = '0;
    for (int i = 0; i < 3; i++) begin
      t[i] = 0; m_start[i] = 0; m_act[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
      m_cur[i] = '0; m_pdata[i] = '0; m_hold[i] = '0; psclk[i] = 0;
      clear(i);
    end
    repeat (3) @(posedge gclk);
    @(negedge gclk);
    chk("rst_busy", busy, 3'b000);
    chk("rst_sclk", sclk, 3'b000);
    chk("rst_latch", latch, 3'b000);
    chk("rst_done", done, 3'b000);
    chk("rst_ovr", ovr, 3'b000);
    chk("rst_data", {q0, q1, q2}, 5'b0);
    rst = '0;

    // single frame, MSB first
    clear(0);
    tick(0, 1'b1, 168'hA53C, 1'b0);
    idle(0, 38);
    chk("f1_chain1", cap[0][1][7:0], 8'hA5);
    chk("f1_chain0", cap[0][0][7:0], 8'h3C);
    chk("f1_rises", rises[0], 8);

    // pending frame B queued during A
    a = 16'($urandom()); b = 16'($urandom());
    clear(0);
    tick(0, 1'b1, {152'b0, a}, 1'b0); idle(0, 9);
    tick(0, 1'b1, {152'b0, b}, 1'b0); idle(0, 65);
    chk("pend_c1", cap[0][1][15:0], {a[15:8], b[15:8]});
    chk("pend_c0", cap[0][0][15:0], {a[7:0], b[7:0]});

    // C replaces pending B
    a = 16'($urandom()); b = 16'($urandom()); c16 = 16'($urandom());
    clear(0);
    tick(0, 1'b1, {152'b0, a}, 1'b0); idle(0, 9);
    tick(0, 1'b1, {152'b0, b}, 1'b0); idle(0, 9);
    tick(0, 1'b1, {152'b0, c16}, 1'b0); idle(0, 55);
    chk("ovr_cnt", ovr_cnt[0], 1);
    chk("ovr_c1", cap[0][1][15:0], {a[15:8], c16[15:8]});
    chk("ovr_c0", cap[0][0][15:0], {a[7:0], c16[7:0]});

    // reset mid-frame, then a fresh frame
    tick(0, 1'b1, rnd168(), 1'b0); idle(0, 14);
    tick(0, 1'b0, '0, 1'b1); idle(0, 40);
    e = 16'($urandom());
    clear(0);
    tick(0, 1'b1, {152'b0, e}, 1'b0); idle(0, 38);
    chk("post_rst", {cap[0][1][7:0], cap[0][0][7:0]}, e);

    // start in the done cycle, nothing pending
    f = 16'($urandom()); g = 16'($urandom());
    clear(0);
    tick(0, 1'b1, {152'b0, f}, 1'b0); idle(0, 34);
    tick(0, 1'b1, {152'b0, g}, 1'b0); idle(0, 40);
    chk("dstart_ovr", ovr_cnt[0], 0);
    chk("dstart_c1", cap[0][1][15:0], {f[15:8], g[15:8]});
    chk("dstart_c0", cap[0][0][15:0], {f[7:0], g[7:0]});
    rnd_run(0, 400);

    // LSB first
    clear(1);
    tick(1, 1'b1, 168'h0180, 1'b0); idle(1, 38);
    chk("lsb_c0", cap[1][0][7:0], 8'b0000_0001);
    chk("lsb_c1", cap[1][1][7:0], 8'b1000_0000);
    chk("lsb_rises", rises[1], 8);
    rnd_run(1, 300);

    // defaults
    big = rnd168();
    clear(2);
    tick(2, 1'b1, big, 1'b0); idle(2, 172);
    chk("def_rises", rises[2], 84);
    chk("def_frame", cap[2][0], big[83:0]);
    rnd_run(2, 600);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
